// File: rtl/pixel_compositor.sv
// Per-pixel layer compositor: picks player/map/backdrop/solid, reads the sprite sheet, and drives aligned RGB and syncs.
// Optional macro PIXEL_COMPOSITOR_TRANSPARENCY_EN keys out KEY_COLOR on the player layer.
module pixel_compositor #(
    parameter logic [11:0] BG_COLOR  = 12'h000,
    parameter logic [11:0] KEY_COLOR = 12'h0F0,
    parameter int          BLINK_BIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  state,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        map_obj,
    input  logic [16:0] map_addr,
    input  logic        player_obj,
    input  logic [16:0] player_addr,
    input  logic        blink_en,
    output logic [16:0] mem_addr,
    input  logic [11:0] mem_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync_o,
    output logic        vsync_o
);

    typedef enum logic [1:0] {
        SEL_SOLID = 2'd0,
        SEL_MEM   = 2'd1
    } sel_t;

    localparam logic [18:0] FRAME_PIX   = 19'd76800;
    localparam logic [18:0] FRAME_PIX_2 = 19'd153600;

    logic [16:0] mem_addr_q, mem_addr_d;
    sel_t        sel1_q, sel1_d, sel2_q;
    logic [11:0] solid1_q, solid1_d, solid2_q;
    logic        player1_q, player1_d, player2_q;
    logic        valid1_q, valid2_q;
    logic        hs1_q, hs2_q, hs3_q;
    logic        vs1_q, vs2_q, vs3_q;
    logic [11:0] rgb_q, rgb_d;
    logic [5:0]  frame_cnt_q, frame_cnt_d;
    logic        vs_prev_q;

    logic [8:0]  pix_x, pix_y;
    logic [18:0] lin_addr, lin_mod;
    logic        is_stage, is_backdrop, player_blanked;

    assign pix_x = h_cnt[9:1];
    assign pix_y = v_cnt[9:1];

    // x + 320*y as shifts; the raw sum stays below 3 frames, so two conditional subtracts give the modulo.
    assign lin_addr = {10'd0, pix_x} + {2'd0, pix_y, 8'd0} + {4'd0, pix_y, 6'd0};

    always_comb begin
        lin_mod = lin_addr;
        if (lin_addr >= FRAME_PIX_2) begin
            lin_mod = lin_addr - FRAME_PIX_2;
        end else if (lin_addr >= FRAME_PIX) begin
            lin_mod = lin_addr - FRAME_PIX;
        end
    end

    assign is_stage       = (state == 4'd2) || (state == 4'd4) || (state == 4'd6);
    assign is_backdrop    = (state <= 4'd8) && !is_stage;
    assign player_blanked = blink_en && frame_cnt_q[BLINK_BIT];

    always_comb begin
        sel1_d     = SEL_SOLID;
        mem_addr_d = mem_addr_q;
        solid1_d   = BG_COLOR;
        player1_d  = 1'b0;
        if (is_stage) begin
            if (player_obj && !player_blanked) begin
                sel1_d     = SEL_MEM;
                mem_addr_d = player_addr;
                player1_d  = 1'b1;
            end else if (map_obj) begin
                sel1_d     = SEL_MEM;
                mem_addr_d = map_addr;
            end
        end else if (is_backdrop) begin
            sel1_d     = SEL_MEM;
            mem_addr_d = lin_mod[16:0];
        end
    end

    assign frame_cnt_d = (vs_prev_q && !vsync) ? frame_cnt_q + 6'd1 : frame_cnt_q;

`ifdef PIXEL_COMPOSITOR_TRANSPARENCY_EN
    always_comb begin
        rgb_d = 12'h000;
        if (valid2_q) begin
            if (sel2_q == SEL_MEM) begin
                rgb_d = (player2_q && (mem_data == KEY_COLOR)) ? BG_COLOR : mem_data;
            end else begin
                rgb_d = solid2_q;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{h_cnt[0], v_cnt[0], lin_mod[18:17]};
`else
    always_comb begin
        rgb_d = 12'h000;
        if (valid2_q) begin
            rgb_d = (sel2_q == SEL_MEM) ? mem_data : solid2_q;
        end
    end

    // Player tracking and the key only matter when transparency is built in.
    logic unused_bits;
    assign unused_bits = ^{h_cnt[0], v_cnt[0], lin_mod[18:17], KEY_COLOR, player2_q};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q  <= 17'd0;
            sel1_q      <= SEL_SOLID;
            sel2_q      <= SEL_SOLID;
            solid1_q    <= 12'h000;
            solid2_q    <= 12'h000;
            player1_q   <= 1'b0;
            player2_q   <= 1'b0;
            valid1_q    <= 1'b0;
            valid2_q    <= 1'b0;
            hs1_q       <= 1'b1;
            hs2_q       <= 1'b1;
            hs3_q       <= 1'b1;
            vs1_q       <= 1'b1;
            vs2_q       <= 1'b1;
            vs3_q       <= 1'b1;
            rgb_q       <= 12'h000;
            frame_cnt_q <= 6'd0;
            vs_prev_q   <= 1'b1;
        end else begin
            mem_addr_q  <= mem_addr_d;
            sel1_q      <= sel1_d;
            solid1_q    <= solid1_d;
            player1_q   <= player1_d;
            valid1_q    <= valid;
            hs1_q       <= hsync;
            vs1_q       <= vsync;
            sel2_q      <= sel1_q;
            solid2_q    <= solid1_q;
            player2_q   <= player1_q;
            valid2_q    <= valid1_q;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
            rgb_q       <= rgb_d;
            hs3_q       <= hs2_q;
            vs3_q       <= vs2_q;
            frame_cnt_q <= frame_cnt_d;
            vs_prev_q   <= vsync;
        end
    end

    assign mem_addr = mem_addr_q;
    assign vga_r    = rgb_q[11:8];
    assign vga_g    = rgb_q[7:4];
    assign vga_b    = rgb_q[3:0];
    assign hsync_o  = hs3_q;
    assign vsync_o  = vs3_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor: reset, backdrop addressing, priority, solid states, blanking/key, blink counter.
module tb_pixel_compositor;

  localparam logic [11:0] BG = 12'h357;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  state = 4'd0;
  logic [9:0]  h_cnt = 10'd0;
  logic [9:0]  v_cnt = 10'd0;
  logic        valid = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        map_obj = 1'b0;
  logic [16:0] map_addr = 17'd0;
  logic        player_obj = 1'b0;
  logic [16:0] player_addr = 17'd0;
  logic        blink_en = 1'b0;
  logic [16:0] mem_addr;
  logic [11:0] mem_data = 12'h000;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync_o, vsync_o;
  logic [11:0] rgb;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign rgb = {vga_r, vga_g, vga_b};

  pixel_compositor #(.BG_COLOR(BG), .KEY_COLOR(12'h0F0), .BLINK_BIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .valid(valid), .hsync(hsync), .vsync(vsync),
    .map_obj(map_obj), .map_addr(map_addr),
    .player_obj(player_obj), .player_addr(player_addr), .blink_en(blink_en),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // synchronous-read sprite sheet model
  function automatic logic [11:0] mem_model(input logic [16:0] a);
    case (a)
      17'd8050:  return 12'hABC;
      17'd100:   return 12'h123;
      17'd38400: return 12'h456;
      17'd200:   return 12'h0F0;
      default:   return a[11:0] ^ 12'h5A5;
    endcase
  endfunction

  always @(posedge clk) mem_data <= mem_model(mem_addr);

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vs_edges(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b0;
      @(negedge clk);
      vsync = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic set_pixel(input logic [3:0] st, input logic [9:0] h, input logic [9:0] v, input logic vl);
    state = st; h_cnt = h; v_cnt = v; valid = vl;
  endtask

  task automatic test_reset();
    logic [30:0] got;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      state = 4'($urandom_range(0, 15));
      h_cnt = 10'($urandom_range(0, 639));
      v_cnt = 10'($urandom_range(0, 479));
      valid = 1'($urandom_range(0, 1));
      hsync = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
      map_obj = 1'($urandom_range(0, 1));
      player_obj = 1'($urandom_range(0, 1));
      map_addr = 17'($urandom_range(0, 76799));
      player_addr = 17'($urandom_range(0, 76799));
      @(negedge clk);
      got = {rgb, hsync_o, vsync_o, mem_addr};
      total_cnt++;
      if (got !== {12'h000, 1'b1, 1'b1, 17'd0}) $display("FAIL reset_hold[%0d] got %h want %h", i, got, {12'h000, 1'b1, 1'b1, 17'd0});
      else pass_cnt++;
    end
    set_pixel(4'd0, 10'd100, 10'd50, 1'b1);
    hsync = 1'b1; vsync = 1'b1; map_obj = 1'b0; player_obj = 1'b0; blink_en = 1'b0;
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total_cnt++;
      if (rgb !== ((c == 3) ? 12'hABC : 12'h000)) $display("FAIL reset_release_c%0d got %h want %h", c, rgb, (c == 3) ? 12'hABC : 12'h000);
      else pass_cnt++;
    end
    hsync = 1'b0;
    wait_cycles(3);
    #2 rst_n = 1'b0;
    #1;
    got = {rgb, hsync_o, vsync_o, mem_addr};
    total_cnt++;
    if (got !== {12'h000, 1'b1, 1'b1, 17'd0}) $display("FAIL reset_midframe got %h want %h", got, {12'h000, 1'b1, 1'b1, 17'd0});
    else pass_cnt++;
    hsync = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_backdrop();
    set_pixel(4'd0, 10'd100, 10'd50, 1'b1);
    hsync = 1'b1;
    wait_cycles(4);
    hsync = 1'b0;
    @(negedge clk);
    hsync = 1'b1;
    total_cnt++;
    if (mem_addr !== 17'd8050) $display("FAIL backdrop_addr got %0d want 8050", mem_addr);
    else pass_cnt++;
    total_cnt++;
    if (hsync_o !== 1'b1) $display("FAIL hsync_d1 got %b want 1", hsync_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (hsync_o !== 1'b1) $display("FAIL hsync_d2 got %b want 1", hsync_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (hsync_o !== 1'b0) $display("FAIL hsync_d3 got %b want 0", hsync_o);
    else pass_cnt++;
    total_cnt++;
    if (rgb !== 12'hABC) $display("FAIL backdrop_rgb got %h want abc", rgb);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (hsync_o !== 1'b1) $display("FAIL hsync_d4 got %b want 1", hsync_o);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    set_pixel(4'd4, 10'd10, 10'd10, 1'b1);
    blink_en = 1'b0;
    player_obj = 1'b1; player_addr = 17'd100;
    map_obj = 1'b1; map_addr = 17'd38400;
    @(negedge clk);
    total_cnt++;
    if (mem_addr !== 17'd100) $display("FAIL prio_both_addr got %0d want 100", mem_addr);
    else pass_cnt++;
    wait_cycles(2);
    total_cnt++;
    if (rgb !== 12'h123) $display("FAIL prio_both_rgb got %h want 123", rgb);
    else pass_cnt++;
    player_obj = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (mem_addr !== 17'd38400) $display("FAIL prio_map_addr got %0d want 38400", mem_addr);
    else pass_cnt++;
    wait_cycles(2);
    total_cnt++;
    if (rgb !== 12'h456) $display("FAIL prio_map_rgb got %h want 456", rgb);
    else pass_cnt++;
    map_obj = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (mem_addr !== 17'd38400) $display("FAIL prio_none_addr_hold got %0d want 38400", mem_addr);
    else pass_cnt++;
    wait_cycles(2);
    total_cnt++;
    if (rgb !== BG) $display("FAIL prio_none_rgb got %h want %h", rgb, BG);
    else pass_cnt++;
  endtask

  task automatic test_solid_states();
    set_pixel(4'd9, 10'd100, 10'd50, 1'b1);
    player_obj = 1'b1; player_addr = 17'd100;
    map_obj = 1'b1; map_addr = 17'd38400;
    wait_cycles(3);
    total_cnt++;
    if (rgb !== BG) $display("FAIL state9_rgb got %h want %h", rgb, BG);
    else pass_cnt++;
    set_pixel(4'd3, 10'd639, 10'd479, 1'b1);
    @(negedge clk);
    total_cnt++;
    if (mem_addr !== 17'd76799) $display("FAIL backdrop_last_addr got %0d want 76799", mem_addr);
    else pass_cnt++;
    wait_cycles(2);
    total_cnt++;
    if (rgb !== 12'hE5A) $display("FAIL backdrop_last_rgb got %h want e5a", rgb);
    else pass_cnt++;
    set_pixel(4'd8, 10'd2, 10'd2, 1'b1);
    wait_cycles(3);
    total_cnt++;
    if (rgb !== 12'h4E4) $display("FAIL fail_state_rgb got %h want 4e4", rgb);
    else pass_cnt++;
  endtask

  task automatic test_blank_transparency();
    logic [11:0] exp_key;
    player_obj = 1'b0; map_obj = 1'b0; blink_en = 1'b0;
    set_pixel(4'd0, 10'd100, 10'd50, 1'b0);
    wait_cycles(3);
    total_cnt++;
    if (rgb !== 12'h000) $display("FAIL blank_mem_rgb got %h want 000", rgb);
    else pass_cnt++;
`ifdef PIXEL_COMPOSITOR_TRANSPARENCY_EN
    exp_key = BG;
`else
    exp_key = 12'h0F0;
`endif
    set_pixel(4'd2, 10'd4, 10'd4, 1'b1);
    player_obj = 1'b1; player_addr = 17'd200;
    wait_cycles(3);
    total_cnt++;
    if (rgb !== exp_key) $display("FAIL player_key_rgb got %h want %h", rgb, exp_key);
    else pass_cnt++;
    player_obj = 1'b0; map_obj = 1'b1; map_addr = 17'd200;
    wait_cycles(3);
    total_cnt++;
    if (rgb !== 12'h0F0) $display("FAIL map_key_rgb got %h want 0f0", rgb);
    else pass_cnt++;
    map_obj = 1'b0;
  endtask

  task automatic test_blink();
    rst_n = 1'b0;
    vsync = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    set_pixel(4'd1, 10'd8, 10'd8, 1'b1);
    map_obj = 1'b0; player_obj = 1'b0;
    @(negedge clk);
    set_pixel(4'd2, 10'd8, 10'd8, 1'b1);
    blink_en = 1'b1; player_obj = 1'b1; player_addr = 17'd100;
    wait_cycles(3);
    total_cnt++;
    if (rgb !== 12'h123) $display("FAIL blink_f0_rgb got %h want 123", rgb);
    else pass_cnt++;
    vs_edges(8);
    wait_cycles(3);
    total_cnt++;
    if (rgb !== BG) $display("FAIL blink_f8_rgb got %h want %h", rgb, BG);
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== 17'd100) $display("FAIL blink_f8_addr_hold got %0d want 100", mem_addr);
    else pass_cnt++;
    vs_edges(8);
    wait_cycles(3);
    total_cnt++;
    if (rgb !== 12'h123) $display("FAIL blink_f16_rgb got %h want 123", rgb);
    else pass_cnt++;
    vs_edges(48);
    wait_cycles(3);
    total_cnt++;
    if (rgb !== 12'h123) $display("FAIL blink_wrap0_rgb got %h want 123", rgb);
    else pass_cnt++;
    vs_edges(8);
    wait_cycles(3);
    total_cnt++;
    if (rgb !== BG) $display("FAIL blink_wrap8_rgb got %h want %h", rgb, BG);
    else pass_cnt++;
    blink_en = 1'b0;
    wait_cycles(3);
    total_cnt++;
    if (rgb !== 12'h123) $display("FAIL blink_disabled_rgb got %h want 123", rgb);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_backdrop();
    test_priority();
    test_solid_states();
    test_blank_transparency();
    test_blink();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
